// File: rtl/lwe_pkg.sv
// Shared definitions for the streaming LWE encryptor: FSM state encoding,
// default geometry, and the counter-width helper.
package lwe_pkg;

  localparam int PW_DEF       = 8;
  localparam int CW_DEF       = 10;
  localparam int BIG_N_DEF    = 30;
  localparam int LITTLE_N_DEF = 2;

  // A counter that must hold values 0..n-1 needs clog2(n) bits, never fewer than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DELTA_SHIFT  = CW_DEF - PW_DEF;
  localparam int SAMPLE_CNT_W = cnt_w(BIG_N_DEF);
  localparam int WORD_IDX_W   = cnt_w(LITTLE_N_DEF + 1);

  typedef logic [CW_DEF-1:0] ct_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

endpackage

// File: rtl/lwe_vec_accum.sv
// (LITTLE_N+1)-word accumulator: init with b preload, masked add mod 2^CW,
// and a read port that returns the post-update value of the selected word.
module lwe_vec_accum import lwe_pkg::*; #(
  parameter int CW = CW_DEF,
  parameter int LN = LITTLE_N_DEF,
  parameter int IW = WORD_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init,
  input  logic [CW-1:0]        b_init,
  input  logic                 add_en,
  input  logic [(LN+1)*CW-1:0] add_vec,
  input  logic [IW-1:0]        rd_idx,
  output logic [CW-1:0]        rd_word
);

  logic [CW-1:0] acc_r   [0:LN];
  logic [CW-1:0] nxt_pad_s [0:(1<<IW)-1];

  for (genvar j = 0; j < (1 << IW); j++) begin : g_word
    if (j <= LN) begin : g_real
      // Sum truncates to CW bits, which is exactly the reduction mod q.
      assign nxt_pad_s[j] = add_en ? (acc_r[j] + add_vec[j*CW +: CW]) : acc_r[j];

      // Per-word register: preload on init, otherwise take the (possibly added) next value.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_r[j] <= {CW{1'b0}};
        end else if (init) begin
          acc_r[j] <= (j == LN) ? b_init : {CW{1'b0}};
        end else begin
          acc_r[j] <= nxt_pad_s[j];
        end
      end
    end else begin : g_pad
      assign nxt_pad_s[j] = {CW{1'b0}};
    end
  end

  assign rd_word = nxt_pad_s[rd_idx];

endmodule

// File: rtl/lwe_encrypt_stream.sv
// Streaming Regev-style LWE encryptor: accumulates selected public-key samples
// and emits the (n+1)-word ciphertext under valid/ready handshakes.
module lwe_encrypt_stream import lwe_pkg::*; #(
  parameter int PLAINTEXT_WIDTH  = PW_DEF,
  parameter int CIPHERTEXT_WIDTH = CW_DEF,
  parameter int BIG_N            = BIG_N_DEF,
  parameter int LITTLE_N         = LITTLE_N_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   go,
  input  logic                                   abort,
  input  logic [PLAINTEXT_WIDTH-1:0]             plaintext,
  input  logic [BIG_N-1:0]                       noise_select,
  output logic                                   busy,
  input  logic                                   pk_valid,
  output logic                                   pk_ready,
  input  logic [(LITTLE_N+1)*CIPHERTEXT_WIDTH-1:0] pk_sample,
  output logic                                   ct_valid,
  input  logic                                   ct_ready,
  output logic [CIPHERTEXT_WIDTH-1:0]            ct_word,
  output logic                                   ct_last,
  output logic                                   done
);

  localparam int CW      = CIPHERTEXT_WIDTH;
  localparam int SCNT_W  = cnt_w(BIG_N);
  localparam int WIDX_W  = cnt_w(LITTLE_N + 1);
  localparam int D_SHIFT = CIPHERTEXT_WIDTH - PLAINTEXT_WIDTH;

  state_t              state_r;
  logic [SCNT_W-1:0]   sample_cnt_r;
  logic [WIDX_W-1:0]   word_idx_r;
  logic [BIG_N-1:0]    sel_r;
  logic                busy_r, pk_ready_r, ct_valid_r, ct_last_r, done_r;
  logic [CW-1:0]       ct_word_r;

  logic                start_s, pk_beat_s, ct_beat_s, add_en_s;
  logic [WIDX_W-1:0]   word_idx_nxt_s, rd_idx_s;
  logic [CW-1:0]       b_init_s, rd_word_s;

  // m * Delta: plaintext placed in the top PLAINTEXT_WIDTH bits.
  assign b_init_s = {plaintext, {D_SHIFT{1'b0}}};

  // Handshake qualifiers and accumulator control.
  always_comb begin
    start_s        = (state_r == IDLE) && go && !abort;
    pk_beat_s      = pk_valid && pk_ready_r;
    ct_beat_s      = ct_valid_r && ct_ready;
    add_en_s       = (state_r == ACCUM) && pk_beat_s && !abort && sel_r[sample_cnt_r];
    word_idx_nxt_s = word_idx_r + WIDX_W'(1);
    rd_idx_s       = (state_r == EMIT) ? word_idx_nxt_s : {WIDX_W{1'b0}};
  end

  lwe_vec_accum #(
    .CW (CW),
    .LN (LITTLE_N),
    .IW (WIDX_W)
  ) u_accum (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (start_s),
    .b_init  (b_init_s),
    .add_en  (add_en_s),
    .add_vec (pk_sample),
    .rd_idx  (rd_idx_s),
    .rd_word (rd_word_s)
  );

  // Control FSM; ct_word is loaded from the accumulator's next value so it is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      sample_cnt_r <= {SCNT_W{1'b0}};
      word_idx_r   <= {WIDX_W{1'b0}};
      sel_r        <= {BIG_N{1'b0}};
      busy_r       <= 1'b0;
      pk_ready_r   <= 1'b0;
      ct_valid_r   <= 1'b0;
      ct_last_r    <= 1'b0;
      ct_word_r    <= {CW{1'b0}};
      done_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start_s) begin
            sel_r        <= noise_select;
            sample_cnt_r <= {SCNT_W{1'b0}};
            state_r      <= ACCUM;
            busy_r       <= 1'b1;
            pk_ready_r   <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCUM: begin
          if (abort) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            pk_ready_r <= 1'b0;
          end else if (pk_beat_s) begin
            if (sample_cnt_r == SCNT_W'(BIG_N - 1)) begin
              state_r    <= EMIT;
              pk_ready_r <= 1'b0;
              ct_valid_r <= 1'b1;
              word_idx_r <= {WIDX_W{1'b0}};
              ct_word_r  <= rd_word_s;
              ct_last_r  <= (LITTLE_N == 0);
            end else begin
              sample_cnt_r <= sample_cnt_r + SCNT_W'(1);
            end
          end else begin
            state_r <= ACCUM;
          end
        end
        EMIT: begin
          if (abort) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            ct_valid_r <= 1'b0;
            ct_last_r  <= 1'b0;
            ct_word_r  <= {CW{1'b0}};
          end else if (ct_beat_s) begin
            if (word_idx_r == WIDX_W'(LITTLE_N)) begin
              state_r    <= IDLE;
              busy_r     <= 1'b0;
              ct_valid_r <= 1'b0;
              ct_last_r  <= 1'b0;
              ct_word_r  <= {CW{1'b0}};
              done_r     <= 1'b1;
            end else begin
              word_idx_r <= word_idx_nxt_s;
              ct_word_r  <= rd_word_s;
              ct_last_r  <= (word_idx_nxt_s == WIDX_W'(LITTLE_N));
            end
          end else begin
            state_r <= EMIT;
          end
        end
        default: begin
          state_r    <= IDLE;
          busy_r     <= 1'b0;
          pk_ready_r <= 1'b0;
          ct_valid_r <= 1'b0;
          ct_last_r  <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign pk_ready = pk_ready_r;
  assign ct_valid = ct_valid_r;
  assign ct_word  = ct_word_r;
  assign ct_last  = ct_last_r;
  assign done     = done_r;

endmodule

// File: tb/tb_lwe_encrypt_stream.sv
// Table-driven bench with an expected-word queue for lwe_encrypt_stream.
module tb_lwe_encrypt_stream;

  localparam int PW = 8;
  localparam int CW = 10;
  localparam int N  = 30;
  localparam int LN = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   go = 1'b0;
  logic                   abort = 1'b0;
  logic [PW-1:0]          plaintext = '0;
  logic [N-1:0]           noise_select = '0;
  logic                   busy;
  logic                   pk_valid = 1'b0;
  logic                   pk_ready;
  logic [(LN+1)*CW-1:0]   pk_sample = '0;
  logic                   ct_valid;
  logic                   ct_ready = 1'b0;
  logic [CW-1:0]          ct_word;
  logic                   ct_last;
  logic                   done;

  lwe_encrypt_stream #(
    .PLAINTEXT_WIDTH (PW),
    .CIPHERTEXT_WIDTH(CW),
    .BIG_N           (N),
    .LITTLE_N        (LN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .go           (go),
    .abort        (abort),
    .plaintext    (plaintext),
    .noise_select (noise_select),
    .busy         (busy),
    .pk_valid     (pk_valid),
    .pk_ready     (pk_ready),
    .pk_sample    (pk_sample),
    .ct_valid     (ct_valid),
    .ct_ready     (ct_ready),
    .ct_word      (ct_word),
    .ct_last      (ct_last),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]           sel;
    logic [PW-1:0]          m;
    int                     pat;
    bit                     use_model;
    logic [LN:0][CW-1:0]    exp;
  } vec_t;

  int            n_total = 0;
  int            n_pass  = 0;
  logic [CW-1:0] smp [N][LN+1];
  logic [CW-1:0] sb [$];
  vec_t          tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic fill(input int pat);
    for (int i = 0; i < N; i++)
      for (int j = 0; j <= LN; j++)
        smp[i][j] = (pat == 2) ? 10'd1023 : CW'($urandom_range(0, 1023));
    if (pat == 1) begin
      smp[0][0] = 10'd100;  smp[0][1] = 10'd200; smp[0][2] = 10'd300;
      smp[1][0] = 10'd1000; smp[1][1] = 10'd900; smp[1][2] = 10'd800;
    end
  endtask

  function automatic logic [CW-1:0] model_word(input int j, input logic [N-1:0] sel,
                                               input logic [PW-1:0] m);
    logic [CW-1:0] a;
    a = (j == LN) ? {m, 2'b00} : '0;
    for (int i = 0; i < N; i++)
      if (sel[i]) a = a + smp[i][j];
    return a;
  endfunction

  task automatic push_exp(input logic [LN:0][CW-1:0] e);
    for (int j = 0; j <= LN; j++) sb.push_back(e[j]);
  endtask

  task automatic go_txn(input logic [N-1:0] sel, input logic [PW-1:0] m);
    @(negedge clk);
    go = 1'b1; noise_select = sel; plaintext = m;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic send(input int lo, input int hi, input bit gaps);
    for (int i = lo; i < hi; i++) begin
      int t;
      if (gaps) begin
        pk_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      pk_valid  = 1'b1;
      pk_sample = {smp[i][2], smp[i][1], smp[i][0]};
      t = 0;
      while (!pk_ready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) check("pk_ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
    end
    pk_valid = 1'b0;
  endtask

  task automatic recv(input bit stall);
    for (int w = 0; w <= LN; w++) begin
      int t;
      logic [CW-1:0] held, e;
      ct_ready = 1'b1;
      t = 0;
      while (!ct_valid && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) begin
        check("ct_valid_timeout", 32'd0, 32'd1);
        ct_ready = 1'b0;
        return;
      end
      if (stall && w == 1) begin
        ct_ready = 1'b0;
        held = ct_word;
        repeat (3) begin
          @(negedge clk);
          check("stall_word", ct_word, held);
          check("stall_valid", ct_valid, 1'b1);
        end
        ct_ready = 1'b1;
      end
      e = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
      check("ct_word", ct_word, e);
      check("ct_last", ct_last, (w == LN));
      @(negedge clk);
    end
    ct_ready = 1'b0;
    check("done_pulse", done, 1'b1);
    check("no_extra_beat", ct_valid, 1'b0);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("queue_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic any_bad;
    tbl[0] = '{sel: '0,               m: 8'd5,   pat: 0, use_model: 1'b0, exp: {10'd20,  10'd0,   10'd0}};
    tbl[1] = '{sel: 30'h3,            m: 8'd1,   pat: 1, use_model: 1'b0, exp: {10'd80,  10'd76,  10'd76}};
    tbl[2] = '{sel: {N{1'b1}},        m: 8'hFF,  pat: 2, use_model: 1'b0, exp: {10'd990, 10'd994, 10'd994}};
    tbl[3] = '{sel: N'($urandom),     m: PW'($urandom), pat: 0, use_model: 1'b1, exp: '0};

    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, pk_ready, ct_valid, ct_last, done, ct_word}, '0);
    rst_n = 1'b1;

    for (int r = 0; r < 4; r++) begin
      logic [LN:0][CW-1:0] e;
      fill(tbl[r].pat);
      e = tbl[r].exp;
      if (tbl[r].use_model)
        for (int j = 0; j <= LN; j++) e[j] = model_word(j, tbl[r].sel, tbl[r].m);
      push_exp(e);
      go_txn(tbl[r].sel, tbl[r].m);
      check("busy_accum", busy, 1'b1);
      send(0, N, 1'b0);
      check("latency", ct_valid, 1'b1);
      recv(1'b0);
    end

    // Backpressure and pk_valid gaps must not change the result.
    fill(1);
    push_exp({10'd80, 10'd76, 10'd76});
    go_txn(30'h3, 8'd1);
    send(0, N, 1'b1);
    recv(1'b1);

    // A second go during ACCUM is ignored.
    fill(1);
    push_exp({10'd80, 10'd76, 10'd76});
    go_txn(30'h3, 8'd1);
    send(0, 5, 1'b0);
    go = 1'b1; noise_select = {N{1'b1}}; plaintext = 8'd200;
    @(negedge clk);
    go = 1'b0;
    send(5, N, 1'b0);
    recv(1'b0);

    // Abort at sample 10, then a fresh run.
    fill(0);
    go_txn({N{1'b1}}, 8'd9);
    send(0, 10, 1'b0);
    pk_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; pk_valid = 1'b0;
    check("abort_idle", {busy, pk_ready, ct_valid}, 3'b000);
    any_bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ct_valid || done || busy) any_bad = 1'b1;
    end
    check("abort_quiet", any_bad, 1'b0);
    fill(1);
    push_exp({10'd80, 10'd76, 10'd76});
    go_txn(30'h3, 8'd1);
    send(0, N, 1'b0);
    recv(1'b0);

    // Reset during EMIT after word 0.
    fill(1);
    push_exp({10'd80, 10'd76, 10'd76});
    go_txn(30'h3, 8'd1);
    send(0, N, 1'b0);
    ct_ready = 1'b1;
    check("pre_reset_w0", ct_word, sb.pop_front());
    @(negedge clk);
    check("pre_reset_w1", ct_word, sb.pop_front());
    #1 rst_n = 1'b0;
    #1 check("async_reset", {busy, pk_ready, ct_valid, ct_last, done, ct_word}, '0);
    sb.delete();
    ct_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_hold_idle", {busy, ct_valid, done}, 3'b000);
    push_exp({10'd80, 10'd76, 10'd76});
    go_txn(30'h3, 8'd1);
    send(0, N, 1'b0);
    recv(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lwe_encrypt_stream.md
Name: lwe_encrypt_stream

Overview:
Sequential, parametrised LWE (Regev-style) encryptor. It streams the N public-key samples in one per cycle under a valid/ready handshake and accumulates the samples chosen by a latched noise-select vector, modulo q = 2^CIPHERTEXT_WIDTH. It adds the encoded plaintext to the b coordinate and emits the (n+1)-word ciphertext one word per beat under a second valid/ready handshake. It sits between the public-key store and the ciphertext output FIFO.

Parameters:
PLAINTEXT_WIDTH, 8, log2(p); must be less than CIPHERTEXT_WIDTH.
CIPHERTEXT_WIDTH, 10, log2(q); all arithmetic is mod 2^CIPHERTEXT_WIDTH by truncation.
BIG_N, 30, number of public-key samples (N).
LITTLE_N, 2, LWE dimension (n); each sample and the ciphertext have LITTLE_N+1 words.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
go  in  1  start request; sampled only in IDLE
abort  in  1  synchronous cancel; returns to IDLE next cycle
plaintext  in  PLAINTEXT_WIDTH  message m; latched on accepted go
noise_select  in  BIG_N  bit i selects sample i; latched on accepted go
busy  out  1  high whenever state != IDLE
pk_valid  in  1  pk_sample is valid
pk_ready  out  1  high in ACCUM
pk_sample  in  (LITTLE_N+1)*CIPHERTEXT_WIDTH  word j at bits [j*CW +: CW]; word LITTLE_N is b
ct_valid  out  1  ct_word is valid
ct_ready  in  1  downstream accepts
ct_word  out  CIPHERTEXT_WIDTH  current ciphertext word; word index 0..LITTLE_N
ct_last  out  1  high with the word-LITTLE_N beat
done  out  1  one-cycle pulse the cycle after the last ct beat is accepted

Behaviour:
- Reset: state IDLE. Accumulators, counters and latched inputs are 0. busy, pk_ready, ct_valid, ct_last, done and ct_word are all 0.
- Delta = 2^(CIPHERTEXT_WIDTH-PLAINTEXT_WIDTH). Encoded message = m * Delta, which is m shifted left into the upper bits.
- IDLE: when go is high, latch plaintext and noise_select, then:
  - acc[0..LITTLE_N-1] = 0
  - acc[LITTLE_N] = m*Delta
  - sample_cnt = 0
  - Move to ACCUM next cycle.
- ACCUM: pk_ready is 1. On each pk_valid&&pk_ready beat:
  - If sel[sample_cnt] is set, acc[j] += pk_sample word j for every j, mod 2^CW.
  - sample_cnt increments.
  - The beat with sample_cnt==BIG_N-1 moves the state to EMIT next cycle.
  - Cycles with pk_valid low change nothing.
- EMIT: ct_valid is 1 and ct_word = acc[word_idx], starting at word_idx 0.
  - On each ct_valid&&ct_ready beat, word_idx increments.
  - ct_last is high when word_idx==LITTLE_N.
  - The last accepted beat moves the state to IDLE, and done pulses on the next cycle.
  - ct_word stays stable while ct_valid&&!ct_ready.
- Latency: minimum go-to-first-ct_valid is BIG_N+1 cycles, since pk_valid is held high.
- Throughput: one sample per cycle in and one word per cycle out.
- go outside IDLE is ignored; latched values do not change.
- abort has priority over every other event in ACCUM or EMIT.
  - Next cycle: state IDLE, pk_ready=0, ct_valid=0.
  - No done pulse is produced.
  - Accumulator contents are don't-care after abort.
  - abort in IDLE has no effect, and go is not accepted in the same cycle as abort.
- rst_n asserted mid-operation forces all reset values asynchronously.
- Counter widths are $clog2(BIG_N) and $clog2(LITTLE_N+1), each with a minimum of 1.
- sample_cnt does not advance past BIG_N-1.

Decomposition:
- Shared package lwe_pkg holds:
  - the state enum {IDLE, ACCUM, EMIT}
  - the localparams DELTA_SHIFT = CW-PW, SAMPLE_CNT_W and WORD_IDX_W
  - the typedef ct_word_t of CIPHERTEXT_WIDTH bits
- One sub-module, lwe_vec_accum, holds the (LITTLE_N+1)-word register file.
  - Operations: init with b-preload, masked add-mod-q, and indexed read.
  - Word adders are instantiated in a generate loop.
- The FSM and counters live in the top module.

Test Plan:
- noise_select=0, m=5, 30 samples of arbitrary data -> ct words {0,0,20}, ct_last on the third beat, done one cycle later.
- noise_select=0x3, m=1, sample0={100,200,300}, sample1={1000,900,800}, rest random -> ct {76,76,80}.
- noise_select=all ones, every word of every sample=1023, m=0xFF -> ct {994,994,990}, which exercises mod-q wrap.
- Rerun the 0x3 case with random pk_valid gaps and ct_ready deasserted for 3 cycles mid-emit -> identical ct {76,76,80}, ct_word stable while stalled, no extra beats.
- go pulsed during ACCUM with different m/select -> ignored, result unchanged; abort at sample 10 -> IDLE next cycle, no ct_valid, no done, and a new go produces a correct ciphertext.
- rst_n low during EMIT after word 0 -> all outputs 0 immediately, state IDLE, next go yields the correct full ciphertext.
